mem_stage_ctrl: RTL
===================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; startin  in  1  reset, asynchronous, active-high.
REQ-002 SHALL accept the EX/MEM register outputs: MEM_wb in 2, MEM_mem_read in 1, MEM_mem_write in 1, MEM_branch in 1, MEM_zero in 1, MEM_branch_target in 32, MEM_alu_result in 32, MEM_forward_b_mux_out in 32, MEM_reg_dst_mux_out in 5.
REQ-003 SHALL drive the data-memory bus: dmem_req out 1, dmem_we out 1, dmem_addr out 32, dmem_wdata out 32; and accept dmem_ack in 1 and dmem_rdata in 32.
REQ-004 SHALL drive the pipeline controls: mem_stall out 1 (freezes PC, IF/ID, ID/EX and EX/MEM), PCSrc out 1, pc_branch_target out 32.
REQ-005 SHALL drive the MEM/WB register outputs: WB_wb out 2, WB_read_data out 32, WB_alu_result out 32, WB_reg_dst_mux_out out 5.
REQ-006 SHALL drive mem_misaligned out 1 (present only under MEM_ALIGN_CHECK_EN; otherwise tied 0).

Function
REQ-007 SHALL implement the FSM states IDLE and REQ.
REQ-008 access = MEM_mem_read | MEM_mem_write; in IDLE with access, SHALL register dmem_addr=MEM_alu_result, dmem_wdata=MEM_forward_b_mux_out, dmem_we=MEM_mem_write, set dmem_req=1, and go to REQ.
REQ-009 SHALL hold dmem_req, dmem_we, dmem_addr and dmem_wdata stable in REQ until dmem_ack=1.
REQ-010 In REQ with dmem_ack=1, SHALL clear dmem_req, return to IDLE, and load MEM/WB with MEM_wb, dmem_rdata (read) or 0 (write), MEM_alu_result and MEM_reg_dst_mux_out.
REQ-011 mem_stall SHALL be combinational: (IDLE & access & !misaligned) | (REQ & !dmem_ack).
REQ-012 Whenever mem_stall=1 at a clock edge, SHALL load a bubble into MEM/WB (WB_wb=0, data fields 0).
REQ-013 In IDLE without access, SHALL load MEM/WB on every edge with MEM_wb, WB_read_data=0, MEM_alu_result and MEM_reg_dst_mux_out; latency is 1 cycle and no stall occurs.
REQ-014 Minimum memory-access latency SHALL be 2 cycles (IDLE edge, then the REQ ack edge); each wait cycle adds 1 cycle; there is no upper bound.
REQ-015 When MEM_mem_read=1 and MEM_mem_write=1 together, SHALL perform a write only; WB_read_data=0.
REQ-016 PCSrc SHALL equal MEM_branch & MEM_zero & !mem_stall; pc_branch_target SHALL equal MEM_branch_target (combinational).
REQ-017 dmem_ack received in IDLE SHALL be ignored.

Reset
REQ-018 startin=1 SHALL immediately force: state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0; WB_wb=0, WB_read_data=0, WB_alu_result=0, WB_reg_dst_mux_out=0; mem_misaligned=0.
REQ-019 A reset asserted in REQ SHALL abort the access: dmem_req drops without an edge, and a later ack is ignored.
REQ-020 Outputs SHALL follow REQ-011 and REQ-016 from the first edge after startin deasserts.

Configuration
REQ-021 With MEM_ALIGN_CHECK_EN defined: an access with MEM_alu_result[1:0]!=0 in IDLE SHALL issue no request and no stall, SHALL load a bubble into MEM/WB, and SHALL assert mem_misaligned for exactly 1 cycle (registered).
REQ-022 Without MEM_ALIGN_CHECK_EN: SHALL not check alignment; the address passes through unmodified; mem_misaligned=0.

Verification
REQ-023 lw, alu_result=0x10, ack 1 cycle after req, rdata=0xDEADBEEF -> mem_stall=1 for 2 cycles, then WB_wb=MEM_wb, WB_read_data=0xDEADBEEF, WB_reg_dst_mux_out=rt.
REQ-024 sw, addr=0x20, wdata=0x12345678, ack delayed 3 cycles -> dmem_req/dmem_we/dmem_addr/dmem_wdata stable for 4 cycles, mem_stall=1 for 4 cycles, bubbles in WB during the stall.
REQ-025 Back-to-back add then beq with zero=1, target=0x40 -> no stall, PCSrc=1, pc_branch_target=0x40, WB shows add result the next cycle.
REQ-026 startin pulsed mid-REQ, then ack=1 -> dmem_req=0 immediately, WB_wb=0, state IDLE, no WB write.
REQ-027 read=write=1 -> dmem_we=1, WB_read_data=0.
REQ-028 With MEM_ALIGN_CHECK_EN, lw at addr 0x13 -> no dmem_req, mem_misaligned=1 for 1 cycle, WB_wb=0.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues data-memory requests, stalls the pipeline until ack, and loads MEM/WB.
// Optional alignment check is enabled with `define MEM_ALIGN_CHECK_EN.
module mem_stage_ctrl (
    input  logic        clk,
    input  logic        startin,
    input  logic [1:0]  MEM_wb,
    input  logic        MEM_mem_read,
    input  logic        MEM_mem_write,
    input  logic        MEM_branch,
    input  logic        MEM_zero,
    input  logic [31:0] MEM_branch_target,
    input  logic [31:0] MEM_alu_result,
    input  logic [31:0] MEM_forward_b_mux_out,
    input  logic [4:0]  MEM_reg_dst_mux_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        PCSrc,
    output logic [31:0] pc_branch_target,
    output logic [1:0]  WB_wb,
    output logic [31:0] WB_read_data,
    output logic [31:0] WB_alu_result,
    output logic [4:0]  WB_reg_dst_mux_out,
    output logic        mem_misaligned
);

    // state | meaning
    // IDLE  | no access outstanding; MEM/WB follows EX/MEM each cycle
    // REQ   | request on the bus, holding it until dmem_ack
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t state, state_next;
    logic   access;
    logic   misaligned;
    logic   issue;
    logic   bubble;
    logic   read_only;

    assign access    = MEM_mem_read | MEM_mem_write;
    // A simultaneous read+write is treated as a write, so no read data returns.
    assign read_only = MEM_mem_read & ~MEM_mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = access & (MEM_alu_result[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (access && !misaligned) state_next = REQ;
            REQ:     if (dmem_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue            = (state == IDLE) && access && !misaligned;
        mem_stall        = issue || ((state == REQ) && !dmem_ack);
        bubble           = mem_stall || ((state == IDLE) && misaligned);
        PCSrc            = MEM_branch & MEM_zero & ~mem_stall;
        pc_branch_target = MEM_branch_target;
    end

    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_wdata <= 32'h0;
        end else if (issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MEM_mem_write;
            dmem_addr  <= MEM_alu_result;
            dmem_wdata <= MEM_forward_b_mux_out;
        end else if ((state == REQ) && dmem_ack) begin
            dmem_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            WB_wb              <= 2'b00;
            WB_read_data       <= 32'h0;
            WB_alu_result      <= 32'h0;
            WB_reg_dst_mux_out <= 5'h0;
        end else if (bubble) begin
            WB_wb              <= 2'b00;
            WB_read_data       <= 32'h0;
            WB_alu_result      <= 32'h0;
            WB_reg_dst_mux_out <= 5'h0;
        end else begin
            WB_wb              <= MEM_wb;
            WB_read_data       <= ((state == REQ) && read_only) ? dmem_rdata : 32'h0;
            WB_alu_result      <= MEM_alu_result;
            WB_reg_dst_mux_out <= MEM_reg_dst_mux_out;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            mem_misaligned <= 1'b0;
        end else begin
            mem_misaligned <= (state == IDLE) && misaligned;
        end
    end
`else
    assign mem_misaligned = 1'b0;
`endif

endmodule
